// File: rtl/led_override.sv
// led_override: passes the bouncer's LED pattern to the pins and lets a Wishbone master take the LEDs over.
// CPU ownership lapses after an idle timeout, or at once on an explicit release. Rev 1.0
`default_nettype none

module led_override #(
  parameter int NLEDS   = 8,
  parameter int TIMEOUT = 100_000_000,
  parameter int TBITS   = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [NLEDS-1:0] i_bounce,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic             i_wb_addr,
  input  logic [31:0]      i_wb_data,
  input  logic [3:0]       i_wb_sel,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  output logic [NLEDS-1:0] o_leds
);

  typedef enum logic {
    AUTO = 1'b0,
    CPU  = 1'b1
  } state_t;

  localparam logic [TBITS-1:0] RELOAD = TBITS'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [NLEDS-1:0] value, value_next;
  logic             hold, hold_next;
  logic [TBITS-1:0] counter, counter_next;

  logic             req;
  logic             value_wr;
  logic             ctrl_wr;
  logic             cpu_owns;
  logic [31:0]      value_rd;
  logic [31:0]      ctrl_rd;

  assign req      = i_wb_cyc && i_wb_stb;
  assign value_wr = req && i_wb_we && !i_wb_addr && i_wb_sel[0];
  assign ctrl_wr  = req && i_wb_we &&  i_wb_addr && i_wb_sel[0];
  assign cpu_owns = (state == CPU);

  assign value_rd = {cpu_owns, {(31-NLEDS){1'b0}}, o_leds};
  assign ctrl_rd  = {30'b0, cpu_owns, hold};

  assign o_wb_stall = 1'b0;

  // Data bits above the LED field and the upper byte selects have no storage.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, i_wb_data[31:NLEDS], i_wb_sel[3:1]};

  always_comb begin
    state_next   = state;
    value_next   = value;
    hold_next    = hold;
    counter_next = counter;

    if (state == CPU && !hold) begin
      if (counter != '0) begin
        counter_next = counter - 1'b1;
      end else begin
        state_next = AUTO;
      end
    end

    if (ctrl_wr) begin
      hold_next = i_wb_data[0];
      if (i_wb_data[1]) begin
        state_next   = AUTO;
        counter_next = '0;
      end
    end

    // A VALUE write overrides a same-cycle expiry and restarts the idle window.
    if (value_wr) begin
      value_next   = i_wb_data[NLEDS-1:0];
      state_next   = CPU;
      counter_next = RELOAD;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= AUTO;
      value     <= '0;
      hold      <= 1'b0;
      counter   <= '0;
      o_leds    <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      state     <= state_next;
      value     <= value_next;
      hold      <= hold_next;
      counter   <= counter_next;
      o_leds    <= cpu_owns ? value : i_bounce;
      o_wb_ack  <= req;
      o_wb_data <= req ? (i_wb_addr ? ctrl_rd : value_rd) : 32'b0;
    end
  end

endmodule

`default_nettype wire
